// File: rtl/camera_gray_downscaler_pkg.sv
// Shared sizes and FSM encoding for the OV7670 luma box-downscaler.
// Imported by the interface, the row accumulator and the top.
package camera_gray_downscaler_pkg;

    localparam int DEF_IN_W = 640;
    localparam int DEF_IN_H = 480;
    localparam int OUT_W    = 160;
    localparam int OUT_H    = 120;
    localparam int ADDR_W   = 15;
    localparam int PIX_X_W  = $clog2(OUT_W);
    localparam int PIX_Y_W  = $clog2(OUT_H);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/camera_gray_downscaler_if.sv
// Camera pins, frame control and downscaled pixel stream as one bundle.
// master drives the camera side, slave is the downscaler.
interface camera_gray_downscaler_if;
    import camera_gray_downscaler_pkg::*;

    logic               cam_vsync;
    logic               cam_href;
    logic [7:0]         cam_data;
    logic               frame_req;
    logic               busy;
    logic               frame_start;
    logic               pix_valid;
    logic [7:0]         pix_data;
    logic [PIX_X_W-1:0] pix_x;
    logic [PIX_Y_W-1:0] pix_y;
    logic [ADDR_W-1:0]  pix_addr;
    logic               frame_done;
    logic               frame_err;

    modport master (
        output cam_vsync, cam_href, cam_data, frame_req,
        input  busy, frame_start, pix_valid, pix_data,
        input  pix_x, pix_y, pix_addr, frame_done, frame_err
    );

    modport slave (
        input  cam_vsync, cam_href, cam_data, frame_req,
        output busy, frame_start, pix_valid, pix_data,
        output pix_x, pix_y, pix_addr, frame_done, frame_err
    );

endinterface

// File: rtl/camera_gray_downscaler_row_acc.sv
// Per-column vertical accumulator of horizontal block sums.
// Row 0 of a block overwrites, later rows add; readout is acc + hsum.
module camera_gray_downscaler_row_acc
    import camera_gray_downscaler_pkg::*;
#(
    parameter  int DEPTH      = OUT_W,
    parameter  int SCALE_LOG2 = 2,
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int HS_W       = 8 + SCALE_LOG2,
    localparam int AC_W       = 8 + 2 * SCALE_LOG2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_first,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [HS_W-1:0]  i_hsum,
    output logic [7:0]       o_mean
);

    logic [AC_W-1:0] r_acc [DEPTH];
    logic [AC_W-1:0] w_sum;

    assign w_sum  = r_acc[i_idx] + AC_W'(i_hsum);
    // Top byte of the block sum is the truncated mean.
    assign o_mean = w_sum[AC_W-1 -: 8];

    // No reset: every entry is overwritten on the first row of a block.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_acc[i_idx] <= i_first ? AC_W'(i_hsum) : w_sum;
        end
    end

endmodule

// File: rtl/camera_gray_downscaler.sv
// OV7670 YUV422 luma extractor with per-frame-armed 2^S x 2^S box downscale.
// Holds the capture FSM, byte phase, x/line counters and output strobes.
module camera_gray_downscaler
    import camera_gray_downscaler_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int IN_H       = DEF_IN_H,
    parameter int SCALE_LOG2 = 2,
    parameter bit Y_FIRST    = 1'b1
) (
    input logic                     clk,
    input logic                     rst_n,
    camera_gray_downscaler_if.slave bus
);

    localparam int O_W   = IN_W >> SCALE_LOG2;
    localparam int O_H   = IN_H >> SCALE_LOG2;
    localparam int IDX_W = (O_W > 1) ? $clog2(O_W) : 1;
    localparam int HS_W  = 8 + SCALE_LOG2;
    localparam int XC_W  = $clog2(IN_W + 1);
    localparam int LC_W  = $clog2(IN_H + 1);

    localparam logic [XC_W-1:0]   IN_W_C    = XC_W'(IN_W);
    localparam logic [LC_W-1:0]   IN_H_C    = LC_W'(IN_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(O_W * O_H - 1);
    localparam logic [ADDR_W-1:0] O_W_A     = ADDR_W'(O_W);
    // YUYV carries Y on phase 0, UYVY on phase 1.
    localparam logic Y_PHASE = ~Y_FIRST;

    state_t r_state;
    state_t w_next;
    logic   w_err;

    logic                  r_vsync_d;
    logic                  r_href_d;
    logic                  r_phase;
    logic [XC_W-1:0]       r_x;
    logic [LC_W-1:0]       r_line;
    logic [HS_W-1:0]       r_hsum;

    logic                  r_frame_start;
    logic                  r_pix_valid;
    logic [7:0]            r_pix_data;
    logic [PIX_X_W-1:0]    r_pix_x;
    logic [PIX_Y_W-1:0]    r_pix_y;
    logic [ADDR_W-1:0]     r_pix_addr;
    logic                  r_frame_done;
    logic                  r_frame_err;

    logic                  w_cap;
    logic                  w_vs_fall;
    logic                  w_vs_rise;
    logic                  w_href_fall;
    logic                  w_y;
    logic [SCALE_LOG2-1:0] w_sub;
    logic [SCALE_LOG2-1:0] w_row;
    logic                  w_blk_end;
    logic                  w_row_last;
    logic                  w_emit;
    logic                  w_last_pix;
    logic [HS_W-1:0]       w_hsum_full;
    logic [PIX_X_W-1:0]    w_idx;
    logic [PIX_Y_W-1:0]    w_pix_y;
    logic [ADDR_W-1:0]     w_addr;
    logic [7:0]            w_mean;

    assign w_cap       = (r_state == ST_CAPTURE);
    assign w_vs_fall   = r_vsync_d & ~bus.cam_vsync;
    assign w_vs_rise   = ~r_vsync_d & bus.cam_vsync;
    assign w_href_fall = r_href_d & ~bus.cam_href;

    assign w_y = w_cap && bus.cam_href
              && (r_phase == Y_PHASE)
              && (r_x < IN_W_C)
              && (r_line < IN_H_C);

    assign w_sub      = r_x[SCALE_LOG2-1:0];
    assign w_row      = r_line[SCALE_LOG2-1:0];
    assign w_blk_end  = w_y & (&w_sub);
    assign w_row_last = &w_row;
    assign w_emit     = w_blk_end & w_row_last;

    assign w_hsum_full = (w_sub == '0)
                       ? HS_W'(bus.cam_data)
                       : r_hsum + HS_W'(bus.cam_data);

    assign w_idx   = PIX_X_W'(r_x >> SCALE_LOG2);
    assign w_pix_y = PIX_Y_W'(r_line >> SCALE_LOG2);
    assign w_addr  = ADDR_W'(w_pix_y) * O_W_A + ADDR_W'(w_idx);

    assign w_last_pix = w_emit && (w_addr == LAST_ADDR);

    camera_gray_downscaler_row_acc #(
        .DEPTH      (O_W),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_row_acc (
        .clk     (clk),
        .i_we    (w_blk_end & ~w_row_last),
        .i_first (w_row == '0),
        .i_idx   (w_idx[IDX_W-1:0]),
        .i_hsum  (w_hsum_full),
        .o_mean  (w_mean)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.frame_req) w_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_vs_fall) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_last_pix) begin
                    w_next = ST_DONE;
                end else if (w_vs_rise) begin
                    w_next = ST_ARMED;
                    w_err  = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
            r_phase   <= 1'b0;
            r_x       <= '0;
            r_line    <= '0;
            r_hsum    <= '0;
        end else begin
            r_vsync_d <= bus.cam_vsync;
            r_href_d  <= bus.cam_href;
            if (!w_cap || !bus.cam_href) begin
                r_phase <= 1'b0;
                r_x     <= '0;
            end else begin
                r_phase <= ~r_phase;
                if (w_y) r_x <= r_x + 1'b1;
            end
            // Empty lines and lines past the frame height are not counted.
            if (!w_cap) begin
                r_line <= '0;
            end else if (w_href_fall && r_x != '0 && r_line < IN_H_C) begin
                r_line <= r_line + 1'b1;
            end
            if (w_y) r_hsum <= w_hsum_full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_addr    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_start <= w_y && r_line == '0 && r_x == '0;
            r_pix_valid   <= w_emit;
            r_frame_done  <= (r_state == ST_DONE);
            r_frame_err   <= w_err;
            if (w_emit) begin
                r_pix_data <= w_mean;
                r_pix_x    <= w_idx;
                r_pix_y    <= w_pix_y;
                r_pix_addr <= w_addr;
            end
        end
    end

    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.frame_start = r_frame_start;
    assign bus.pix_valid   = r_pix_valid;
    assign bus.pix_data    = r_pix_data;
    assign bus.pix_x       = r_pix_x;
    assign bus.pix_y       = r_pix_y;
    assign bus.pix_addr    = r_pix_addr;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_camera_gray_downscaler.sv
// Directed bench: YUYV and UYVY instances on a reduced 32x16 frame,
// scoreboarded pixel stream plus strobe/busy counters.
`timescale 1ns/1ps
module tb_camera_gray_downscaler;
    import camera_gray_downscaler_pkg::*;

    localparam int W  = 32;
    localparam int H  = 16;
    localparam int OW = W / 4;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       href  = 1'b0;
    logic [7:0] dat_a = 8'h00;
    logic [7:0] dat_b = 8'h00;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    int pix_a, pix_b, extra_a, extra_b;
    int done_a, done_b, err_a, err_b;
    int start_a, busy_seen_a;

    always #5 clk = ~clk;

    camera_gray_downscaler_if bus_a ();
    camera_gray_downscaler_if bus_b ();

    assign bus_a.cam_vsync = vsync;
    assign bus_a.cam_href  = href;
    assign bus_a.cam_data  = dat_a;
    assign bus_a.frame_req = req_a;
    assign bus_b.cam_vsync = vsync;
    assign bus_b.cam_href  = href;
    assign bus_b.cam_data  = dat_b;
    assign bus_b.frame_req = req_b;

    camera_gray_downscaler #(
        .IN_W(W), .IN_H(H), .SCALE_LOG2(2), .Y_FIRST(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
    );

    camera_gray_downscaler #(
        .IN_W(W), .IN_H(H), .SCALE_LOG2(2), .Y_FIRST(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int yv(int mode, int x, int ln);
        case (mode)
            0: return 8'h80;
            1: return (x < 4 && ln < 4) ? ln * 4 + x : 0;
            default: return (x * 7 + ln * 13) % 256;
        endcase
    endfunction

    function automatic int blk_mean(int mode, int bx, int by);
        int s;
        s = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s += yv(mode, bx * 4 + c, by * 4 + r);
        return s >> 4;
    endfunction

    task automatic clear_counts();
        pix_a = 0; pix_b = 0; extra_a = 0; extra_b = 0;
        done_a = 0; done_b = 0; err_a = 0; err_b = 0;
        start_a = 0; busy_seen_a = 0;
    endtask

    task automatic push_row(input int mode, input int by,
                            input bit cap_a, input bit cap_b);
        exp_t e;
        for (int bx = 0; bx < OW; bx++) begin
            e.addr = by * OW + bx;
            e.data = blk_mean(mode, bx, by);
            if (cap_a) q_a.push_back(e);
            if (cap_b) q_b.push_back(e);
        end
    endtask

    // rst_line >= 0 pulls reset halfway through that line and abandons the frame.
    task automatic drive_frame(input int n_lines, input int mode,
                               input bit cap_a, input bit cap_b,
                               input int rst_line);
        int y;
        vsync = 1'b1;
        repeat (4) step();
        vsync = 1'b0;
        repeat (4) step();
        for (int ln = 0; ln < n_lines; ln++) begin
            if (ln % 4 == 3) push_row(mode, ln / 4, cap_a, cap_b);
            href = 1'b1;
            for (int b = 0; b < 2 * W; b++) begin
                if (ln == rst_line && b == W) begin
                    chk("rst_pre_busy", bus_a.busy, 1);
                    chk("rst_pre_addr", bus_a.pix_addr, OW - 1);
                    rst_n = 1'b0;
                    #1;
                    chk("rst_busy", bus_a.busy, 0);
                    chk("rst_addr", bus_a.pix_addr, 0);
                    chk("rst_x", bus_a.pix_x, 0);
                    chk("rst_data", bus_a.pix_data, 0);
                    chk("rst_valid", bus_a.pix_valid, 0);
                    href = 1'b0;
                    repeat (3) step();
                    rst_n = 1'b1;
                    step();
                    return;
                end
                y = yv(mode, b / 2, ln);
                dat_a = (b % 2 == 0) ? 8'(y) : 8'hFF;
                dat_b = (b % 2 == 1) ? 8'(y) : 8'hFF;
                step();
            end
            href = 1'b0;
            repeat (4) step();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.pix_valid === 1'b1) begin
            pix_a++;
            if (q_a.size() == 0) begin
                extra_a++;
            end else begin
                e = q_a.pop_front();
                chk("a_addr", bus_a.pix_addr, e.addr);
                chk("a_data", bus_a.pix_data, e.data);
                chk("a_x", bus_a.pix_x, e.addr % OW);
                chk("a_y", bus_a.pix_y, e.addr / OW);
            end
        end
        if (bus_b.pix_valid === 1'b1) begin
            pix_b++;
            if (q_b.size() == 0) begin
                extra_b++;
            end else begin
                e = q_b.pop_front();
                chk("b_addr", bus_b.pix_addr, e.addr);
                chk("b_data", bus_b.pix_data, e.data);
            end
        end
        if (bus_a.frame_done === 1'b1) done_a++;
        if (bus_b.frame_done === 1'b1) done_b++;
        if (bus_a.frame_err === 1'b1) err_a++;
        if (bus_b.frame_err === 1'b1) err_b++;
        if (bus_a.frame_start === 1'b1) start_a++;
        if (bus_a.busy === 1'b1) busy_seen_a++;
    end

    initial begin
        clear_counts();
        repeat (3) step();
        chk("reset_busy", bus_a.busy, 0);
        chk("reset_valid", bus_a.pix_valid, 0);
        chk("reset_start", bus_a.frame_start, 0);
        chk("reset_done", bus_a.frame_done, 0);
        chk("reset_err", bus_a.frame_err, 0);
        chk("reset_addr", bus_a.pix_addr, 0);
        chk("reset_data", bus_b.pix_data, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Unarmed: a full frame goes by untouched.
        clear_counts();
        drive_frame(H, 0, 1'b0, 1'b0, -1);
        repeat (8) step();
        chk("noreq_pix_a", pix_a, 0);
        chk("noreq_pix_b", pix_b, 0);
        chk("noreq_busy", busy_seen_a, 0);

        // Flat 0x80 luma with 0xFF chroma on both byte orders.
        clear_counts();
        req_a = 1'b1; req_b = 1'b1;
        step();
        req_a = 1'b0; req_b = 1'b0;
        drive_frame(H, 0, 1'b1, 1'b1, -1);
        repeat (8) step();
        chk("flat_pix_a", pix_a, W * H / 16);
        chk("flat_pix_b", pix_b, W * H / 16);
        chk("flat_done_a", done_a, 1);
        chk("flat_done_b", done_b, 1);
        chk("flat_start_a", start_a, 1);
        chk("flat_err_a", err_a, 0);
        chk("flat_busy_end", bus_a.busy, 0);

        // Ramp in block (0,0) only.
        clear_counts();
        req_a = 1'b1; req_b = 1'b1;
        step();
        req_a = 1'b0; req_b = 1'b0;
        drive_frame(H, 1, 1'b1, 1'b1, -1);
        repeat (8) step();
        chk("ramp_pix_a", pix_a, W * H / 16);
        chk("ramp_done_a", done_a, 1);
        chk("ramp_done_b", done_b, 1);

        // Short frame aborts, DUT re-arms and takes the next one.
        clear_counts();
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        drive_frame(H / 2, 0, 1'b1, 1'b0, -1);
        drive_frame(H, 0, 1'b1, 1'b0, -1);
        repeat (8) step();
        chk("short_err_a", err_a, 1);
        chk("short_done_a", done_a, 1);
        chk("short_pix_a", pix_a, W * H / 32 + W * H / 16);
        chk("short_start_a", start_a, 2);
        chk("short_pix_b", pix_b, 0);
        chk("short_err_b", err_b, 0);

        // Reset mid-frame, then a clean capture.
        clear_counts();
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        drive_frame(H, 0, 1'b1, 1'b0, 6);
        chk("rst_done_a", done_a, 0);
        chk("rst_err_a", err_a, 0);
        clear_counts();
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        drive_frame(H, 2, 1'b1, 1'b0, -1);
        repeat (8) step();
        chk("post_rst_pix_a", pix_a, W * H / 16);
        chk("post_rst_done_a", done_a, 1);
        chk("post_rst_err_a", err_a, 0);

        chk("q_a_left", q_a.size(), 0);
        chk("q_b_left", q_b.size(), 0);
        chk("extra_a", extra_a, 0);
        chk("extra_b", extra_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
